// File: rtl/mmio_pkg.sv
// Shared MMIO window map and counter width for the memory-stage load/store select logic.
// Constants only; no timing or flow control of its own.
package mmio_pkg;

  localparam int CNT_W = 32;

  localparam logic [31:0] UART_CTRL_ADDR = 32'h8000_0000;
  localparam logic [31:0] UART_RX_ADDR   = 32'h8000_0004;
  localparam logic [31:0] UART_TX_ADDR   = 32'h8000_0008;
  localparam logic [31:0] CYC_CNT_ADDR   = 32'h8000_000C;
  localparam logic [31:0] INST_CNT_ADDR  = 32'h8000_0010;
  localparam logic [31:0] BR_CNT_ADDR    = 32'h8000_0014;
  localparam logic [31:0] CNT_RST_ADDR   = 32'h8000_0018;
  localparam logic [31:0] CORR_BR_ADDR   = 32'h8000_001C;

endpackage

// File: rtl/mmio_counter.sv
// W-bit wrapping event counter; clear beats increment.
// One cycle from inc/clr to the new count; it never stalls.
module mmio_counter
  import mmio_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/mmio_store_unit.sv
// MMIO store decode: one-entry UART TX holding register (valid/ready, accepted byte visible next cycle,
// stores to a full unready register are dropped) plus four perf counters; MMIO_TX_OVERRUN_EN adds tx_overrun.
module mmio_store_unit
  import mmio_pkg::*;
#(
  parameter int                W_SIZE       = 32,
  parameter logic [W_SIZE-1:0] TX_ADDR      = UART_TX_ADDR,
  parameter logic [W_SIZE-1:0] CNT_RST_ADDR = mmio_pkg::CNT_RST_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              store_en,
  input  logic [W_SIZE-1:0] addr,
  input  logic [W_SIZE-1:0] wdata,
  input  logic [3:0]        wmask,
  input  logic              inst_retire,
  input  logic              br_retire,
  input  logic              br_correct,
  output logic [7:0]        uart_tx_data_out,
  output logic              uart_tx_data_out_valid,
  input  logic              uart_tx_data_out_ready,
  output logic              tx_ready,
`ifdef MMIO_TX_OVERRUN_EN
  output logic              tx_overrun,
`endif
  output logic [CNT_W-1:0]  cyc_count,
  output logic [CNT_W-1:0]  inst_count,
  output logic [CNT_W-1:0]  br_count,
  output logic [CNT_W-1:0]  corr_br_count
);

  logic [7:0] r_tx_data;
  logic       r_tx_vld;
  logic       w_wr;
  logic       w_tx_sel;
  logic       w_tx_acc;
  logic       w_tx_drop;
  logic       w_hs;
  logic       w_clr;
  logic       w_unused;

  assign w_wr      = store_en && (wmask != 4'b0000);
  assign w_tx_sel  = w_wr && (addr == TX_ADDR) && wmask[0];
  assign w_hs      = r_tx_vld && uart_tx_data_out_ready;
  // A full register can still take a byte when the transmitter drains it in the same cycle.
  assign w_tx_acc  = w_tx_sel && (!r_tx_vld || uart_tx_data_out_ready);
  assign w_tx_drop = w_tx_sel && r_tx_vld && !uart_tx_data_out_ready;
  assign w_clr     = w_wr && (addr == CNT_RST_ADDR);
  assign w_unused  = ^{wdata[W_SIZE-1:8], w_tx_drop};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_data <= 8'h00;
      r_tx_vld  <= 1'b0;
    end else if (w_tx_acc) begin
      r_tx_data <= wdata[7:0];
      r_tx_vld  <= 1'b1;
    end else if (w_hs) begin
      r_tx_vld  <= 1'b0;
    end
  end

  assign uart_tx_data_out       = r_tx_data;
  assign uart_tx_data_out_valid = r_tx_vld;
  assign tx_ready               = !r_tx_vld;

`ifdef MMIO_TX_OVERRUN_EN
  logic r_tx_overrun;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_overrun <= 1'b0;
    end else if (w_tx_drop) begin
      r_tx_overrun <= 1'b1;
    end else if (w_clr) begin
      r_tx_overrun <= 1'b0;
    end
  end

  assign tx_overrun = r_tx_overrun;
`endif

  mmio_counter #(.W(CNT_W)) u_cyc (
    .clk(clk), .rst(rst), .i_inc(1'b1), .i_clr(w_clr), .o_count(cyc_count)
  );

  mmio_counter #(.W(CNT_W)) u_inst (
    .clk(clk), .rst(rst), .i_inc(inst_retire), .i_clr(w_clr), .o_count(inst_count)
  );

  mmio_counter #(.W(CNT_W)) u_br (
    .clk(clk), .rst(rst), .i_inc(br_retire), .i_clr(w_clr), .o_count(br_count)
  );

  mmio_counter #(.W(CNT_W)) u_corr_br (
    .clk(clk), .rst(rst), .i_inc(br_retire && br_correct), .i_clr(w_clr), .o_count(corr_br_count)
  );

endmodule

// File: tb/tb_mmio_store_unit.sv
// Directed self-checking bench for mmio_store_unit: UART TX holding register and perf counters.
module tb_mmio_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        store_en;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic        inst_retire;
  logic        br_retire;
  logic        br_correct;
  logic [7:0]  uart_tx_data_out;
  logic        uart_tx_data_out_valid;
  logic        uart_tx_data_out_ready;
  logic        tx_ready;
`ifdef MMIO_TX_OVERRUN_EN
  logic        tx_overrun;
`endif
  logic [31:0] cyc_count;
  logic [31:0] inst_count;
  logic [31:0] br_count;
  logic [31:0] corr_br_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mmio_store_unit dut (
    .clk                    (clk),
    .rst                    (rst),
    .store_en               (store_en),
    .addr                   (addr),
    .wdata                  (wdata),
    .wmask                  (wmask),
    .inst_retire            (inst_retire),
    .br_retire              (br_retire),
    .br_correct             (br_correct),
    .uart_tx_data_out       (uart_tx_data_out),
    .uart_tx_data_out_valid (uart_tx_data_out_valid),
    .uart_tx_data_out_ready (uart_tx_data_out_ready),
    .tx_ready               (tx_ready),
`ifdef MMIO_TX_OVERRUN_EN
    .tx_overrun             (tx_overrun),
`endif
    .cyc_count              (cyc_count),
    .inst_count             (inst_count),
    .br_count               (br_count),
    .corr_br_count          (corr_br_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs are changed and outputs sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    store_en = 1'b1;
    addr     = a;
    wdata    = d;
    wmask    = m;
  endtask

  task automatic no_store();
    store_en = 1'b0;
    addr     = 32'h0;
    wdata    = 32'h0;
    wmask    = 4'h0;
  endtask

  initial begin
    rst = 1'b1;
    no_store();
    inst_retire = 1'b0;
    br_retire = 1'b0;
    br_correct = 1'b0;
    uart_tx_data_out_ready = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_valid", 32'(uart_tx_data_out_valid), 32'h0);
    check("rst_tx_ready", 32'(tx_ready), 32'h1);
    check("rst_data", 32'(uart_tx_data_out), 32'h0);
    check("rst_cyc", cyc_count, 32'h0);
`ifdef MMIO_TX_OVERRUN_EN
    check("rst_overrun", 32'(tx_overrun), 32'h0);
`endif
    rst = 1'b0;

    // Idle 10 cycles
    for (int i = 0; i < 10; i++) tick();
    check("idle_cyc", cyc_count, 32'd10);
    check("idle_inst", inst_count, 32'd0);
    check("idle_br", br_count, 32'd0);
    check("idle_corr", corr_br_count, 32'd0);
    check("idle_valid", 32'(uart_tx_data_out_valid), 32'h0);
    check("idle_tx_ready", 32'(tx_ready), 32'h1);

    // Store 0x41 with transmitter stalled, then handshake
    store(32'h8000_0008, 32'hDEAD_BE41, 4'b0001);
    tick();
    no_store();
    check("tx41_valid", 32'(uart_tx_data_out_valid), 32'h1);
    check("tx41_data", 32'(uart_tx_data_out), 32'h41);
    check("tx41_tx_ready", 32'(tx_ready), 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("tx41_hold_data", 32'(uart_tx_data_out), 32'h41);
      check("tx41_hold_valid", 32'(uart_tx_data_out_valid), 32'h1);
    end
    uart_tx_data_out_ready = 1'b1;
    tick();
    uart_tx_data_out_ready = 1'b0;
    check("tx41_drained_valid", 32'(uart_tx_data_out_valid), 32'h0);
    check("tx41_drained_tx_ready", 32'(tx_ready), 32'h1);

    // Refill during handshake, then overrun
    store(32'h8000_0008, 32'h0000_0050, 4'b0001);
    tick();
    check("tx50_valid", 32'(uart_tx_data_out_valid), 32'h1);
    uart_tx_data_out_ready = 1'b1;
    store(32'h8000_0008, 32'h0000_0042, 4'b0001);
    tick();
    check("refill_valid", 32'(uart_tx_data_out_valid), 32'h1);
    check("refill_data", 32'(uart_tx_data_out), 32'h42);
    uart_tx_data_out_ready = 1'b0;
    store(32'h8000_0008, 32'h0000_0043, 4'b0001);
    tick();
    no_store();
    check("overrun_data", 32'(uart_tx_data_out), 32'h42);
    check("overrun_valid", 32'(uart_tx_data_out_valid), 32'h1);
`ifdef MMIO_TX_OVERRUN_EN
    check("overrun_flag", 32'(tx_overrun), 32'h1);
`endif
    uart_tx_data_out_ready = 1'b1;
    tick();
    uart_tx_data_out_ready = 1'b0;
    check("overrun_drained", 32'(uart_tx_data_out_valid), 32'h0);

    // Retire 7 instructions, 3 branches (2 correct; one stray br_correct without br_retire)
    for (int i = 0; i < 7; i++) begin
      inst_retire = 1'b1;
      br_retire   = (i < 3);
      br_correct  = (i < 2) || (i == 5);
      tick();
    end
    inst_retire = 1'b0;
    br_retire   = 1'b0;
    br_correct  = 1'b0;
    check("ret_inst", inst_count, 32'd7);
    check("ret_br", br_count, 32'd3);
    check("ret_corr", corr_br_count, 32'd2);

    // Clear beats same-cycle increments
    store(32'h8000_0018, 32'h1234_5678, 4'b1000);
    inst_retire = 1'b1;
    br_retire   = 1'b1;
    br_correct  = 1'b1;
    tick();
    no_store();
    inst_retire = 1'b0;
    br_retire   = 1'b0;
    br_correct  = 1'b0;
    check("clr_cyc", cyc_count, 32'd0);
    check("clr_inst", inst_count, 32'd0);
    check("clr_br", br_count, 32'd0);
    check("clr_corr", corr_br_count, 32'd0);
`ifdef MMIO_TX_OVERRUN_EN
    check("clr_overrun", 32'(tx_overrun), 32'h0);
`endif
    tick();
    check("clr_cyc_next", cyc_count, 32'd1);
    check("clr_inst_next", inst_count, 32'd0);

    // Cycle counter wrap
    force dut.u_cyc.r_count = 32'hFFFF_FFFE;
    #1;
    release dut.u_cyc.r_count;
    tick();
    check("wrap_ffffffff", cyc_count, 32'hFFFF_FFFF);
    tick();
    check("wrap_0", cyc_count, 32'h0);
    tick();
    check("wrap_1", cyc_count, 32'h1);

    // Non-writes and non-TX addresses
    store(32'h8000_0008, 32'h0000_0061, 4'b0000);
    tick();
    check("nomask_valid", 32'(uart_tx_data_out_valid), 32'h0);
    store(32'h8000_0008, 32'h0000_6200, 4'b0010);
    tick();
    check("lane1_valid", 32'(uart_tx_data_out_valid), 32'h0);
    store(32'h8000_000C, 32'h0000_0055, 4'b1111);
    tick();
    no_store();
    check("addr0c_valid", 32'(uart_tx_data_out_valid), 32'h0);
    check("addr0c_cyc", cyc_count, 32'd4);
    check("addr0c_inst", inst_count, 32'd0);
    check("addr0c_data", 32'(uart_tx_data_out), 32'h42);

    // Asynchronous reset while a byte is pending
    store(32'h8000_0008, 32'h0000_0077, 4'b0001);
    tick();
    no_store();
    check("pre_rst_valid", 32'(uart_tx_data_out_valid), 32'h1);
    check("pre_rst_data", 32'(uart_tx_data_out), 32'h77);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(uart_tx_data_out_valid), 32'h0);
    check("async_rst_tx_ready", 32'(tx_ready), 32'h1);
    check("async_rst_data", 32'(uart_tx_data_out), 32'h0);
    check("async_rst_cyc", cyc_count, 32'h0);
    #1;
    rst = 1'b0;
    tick();
    check("post_rst_cyc", cyc_count, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mmio_store_unit.md
Name: mmio_store_unit

Overview:
- Store-side (write direction) counterpart of the memory-stage MMIO load select logic.
- Decodes stores in the memory stage whose address is in the 0x8000_00xx MMIO window.
- Owns a one-entry UART transmit holding register with a ready/valid handshake to the UART transmitter.
- Owns the four performance counters (cycle, instruction, branch, correct-branch) and their clear register; exports their values and TX status to the load path.

Parameters:
- W_SIZE, 32, datapath/address width.
- TX_ADDR, 32'h80000008, UART transmit data register.
- CNT_RST_ADDR, 32'h80000018, counter-clear register.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- store_en  in  1  memory-stage instruction is a store and is not squashed
- addr  in  W_SIZE  store address (ALU result)
- wdata  in  W_SIZE  store data, already lane-shifted
- wmask  in  4  byte write mask; 4'b0000 means no write
- inst_retire  in  1  one instruction retires this cycle
- br_retire  in  1  one conditional branch retires this cycle
- br_correct  in  1  retiring branch was predicted correctly; qualified by br_retire
- uart_tx_data_out  out  8  byte to the transmitter
- uart_tx_data_out_valid  out  1  holding register full
- uart_tx_data_out_ready  in  1  transmitter accepts the byte
- tx_ready  out  1  !uart_tx_data_out_valid; feeds UART control bit 0 on the load path
- cyc_count, inst_count, br_count, corr_br_count  out  32 each  counter values

Behaviour:
- Reset (async, rst=1): uart_tx_data_out=0, valid=0, tx_ready=1, all counters=0, tx_overrun=0.
- Address match is exact on the full W_SIZE address. A write occurs only when store_en=1 and wmask!=0. All other addresses are ignored; DMEM and IMEM handle their own writes.
- TX write: store to TX_ADDR with wmask[0]=1 is accepted if valid=0, or if valid=1 and ready=1 in the same cycle (refill).
- Accepted store in cycle N: data=wdata[7:0] and valid=1 from N+1.
- TX handshake: valid&ready in cycle M with no accepted store in M gives valid=0 at M+1.
- Data stays stable while valid=1 and ready=0.
- Store to TX while full and not ready: byte dropped, register unchanged. Software is required to poll tx_ready.
- Counters are 32-bit and wrap 0xFFFF_FFFF to 0 silently.
  - cyc_count increments every cycle.
  - inst_count increments when inst_retire=1.
  - br_count increments when br_retire=1.
  - corr_br_count increments when br_retire&br_correct.
- Counter clear: any store to CNT_RST_ADDR (any data, wmask!=0) in cycle N makes all four counters 0 at N+1.
- Clear wins over increments in cycle N; cyc_count=1 at N+2.
- Counter outputs come directly from registers, so the load path sees values with no added latency.
- Reset asserted mid-transfer drops the pending byte; valid returns to 0 immediately.

Optional Feature:
- Macro MMIO_TX_OVERRUN_EN.
- Defined:
  - Adds output tx_overrun (1 bit) and a sticky flag set on any dropped TX store.
  - The flag is cleared by a store to CNT_RST_ADDR; set wins over clear when both occur in the same cycle.
  - The flag is exposed on UART control bit 2.
- Undefined: port absent; dropped stores leave no trace.

Decomposition:
- Package mmio_pkg holds:
  - MMIO address constants (UART control/receiver/transmit, cycle/inst/branch/correct-branch counters, counter clear), shared with the load-select logic.
  - Counter width constant (32).
- Natural sub-module: mmio_counter, a W-bit counter with inc and clr inputs (clr priority) and async reset, instantiated four times.

Test Plan:
- Reset release, idle 10 cycles -> cyc_count=10, other counters 0, valid=0, tx_ready=1.
- Store 0x41 to 0x80000008 with ready=0, hold 5 cycles, then ready=1 for 1 cycle -> data=0x41 valid from N+1 and stable throughout; valid=0 the cycle after the handshake; tx_ready follows.
- Valid=1 with ready=1 and a same-cycle store of 0x42 -> next cycle valid=1, data=0x42 (refill). Valid=1 with ready=0 and a store of 0x43 -> data stays 0x42; tx_overrun=1 if MMIO_TX_OVERRUN_EN.
- Retire 7 instructions and 3 branches (2 correct), then store to 0x80000018 in the same cycle as inst_retire=1 -> next cycle all counters 0; next cycle cyc_count=1.
- Preload cyc_count near wrap (hierarchical force 0xFFFFFFFE), run 3 cycles -> 0xFFFFFFFF, 0, 1.
- Store to 0x80000008 with wmask=4'b0000, and a store to 0x8000000C -> no valid, counters unaffected. Assert rst asynchronously while valid=1 -> valid=0 before the next clk edge.
